// File: rtl/buttons_ctrl.sv
// Memory-mapped push-button peripheral: two-flop synchronizer, per-button
// debounce, sticky W1C press flags, interrupt enables and a one-cycle read port.
module buttons_ctrl #(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 read_i,
    input  logic                 write_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o,
    input  logic [N_BUTTONS-1:0] buttons_i,
    output logic                 irq_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_BUTTONS-1:0] sync1;
    logic [N_BUTTONS-1:0] sync2;
    logic [N_BUTTONS-1:0] stable;
    logic [N_BUTTONS-1:0] stable_next;
    logic [N_BUTTONS-1:0] rise;
    logic [N_BUTTONS-1:0] edge_flags;
    logic [N_BUTTONS-1:0] irq_en;
    logic [N_BUTTONS-1:0] clr_mask;
    logic [CW-1:0]        cnt      [N_BUTTONS];
    logic [CW-1:0]        cnt_next [N_BUTTONS];
    logic [1:0]           offset;
    logic                 wr;
    logic                 rd;
    logic [31:0]          rd_word;
    logic                 unused_bits;

    assign offset      = addr_i[3:2];
    assign wr          = en_i & write_i;
    assign rd          = en_i & read_i & ~write_i;
    assign unused_bits = ^{addr_i[31:4], addr_i[1:0], wdata_i};

    // A change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        stable_next = stable;
        for (int i = 0; i < N_BUTTONS; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    stable_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise     = stable_next & ~stable;
    assign clr_mask = (wr && offset == 2'd1) ? wdata_i[N_BUTTONS-1:0] : '0;

    always_comb begin
        rd_word = '0;
        case (offset)
            2'd0:    rd_word[N_BUTTONS-1:0] = stable;
            2'd1:    rd_word[N_BUTTONS-1:0] = edge_flags;
            2'd2:    rd_word[N_BUTTONS-1:0] = irq_en;
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1      <= '0;
            sync2      <= '0;
            stable     <= '0;
            edge_flags <= '0;
            irq_en     <= '0;
            rdata_o    <= '0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1  <= buttons_i;
            sync2  <= sync1;
            stable <= stable_next;
            for (int i = 0; i < N_BUTTONS; i++) begin
                cnt[i] <= cnt_next[i];
            end
            // A press landing on the same edge as its W1C clear keeps the flag set.
            edge_flags <= (edge_flags & ~clr_mask) | rise;
            if (wr && offset == 2'd2) begin
                irq_en <= wdata_i[N_BUTTONS-1:0];
            end
            rdata_o <= rd ? rd_word : 32'd0;
        end
    end

    assign irq_o = |(edge_flags & irq_en);

endmodule
